// File: rtl/rs422_pkg.sv
// Shared types and constants for the RS422 loopback test scheduler.
package rs422_pkg;

  localparam int ERR_W    = 32;
  localparam int CH_IDX_W = 4;

  typedef enum logic [6:0] {
    ST_IDLE    = 7'b0000001,
    ST_SELECT  = 7'b0000010,
    ST_START   = 7'b0000100,
    ST_WAIT    = 7'b0001000,
    ST_CAPTURE = 7'b0010000,
    ST_NEXT    = 7'b0100000,
    ST_FINISH  = 7'b1000000
  } state_t;

endpackage

// File: rtl/rs422_ch_pick.sv
// Combinational priority finder: lowest enabled channel index at or above ptr.
module rs422_ch_pick
  import rs422_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = 5
) (
  input  logic [NUM_CH-1:0]   mask,
  input  logic [PTR_W-1:0]    ptr,
  output logic [CH_IDX_W-1:0] idx,
  output logic                valid
);

  logic [NUM_CH-1:0] elig;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_elig
    assign elig[gi] = mask[gi] && (PTR_W'(gi) >= ptr);
  end

  // Scan downwards so the lowest eligible bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        idx   = CH_IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs422_test_sched.sv
// Sequences RS422 loopback channel testers one at a time over a number of
// passes, collecting per-channel error counts, failures and timeouts.
module rs422_test_sched
  import rs422_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter logic [31:0] TIMEOUT_CYC = 32'd600000,
  parameter int          TOT_W       = 48
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     run,
  input  logic                     abort,
  input  logic [7:0]               passes,
  input  logic [NUM_CH-1:0]        ch_enable,
  output logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH-1:0]        ch_finish,
  input  logic [ERR_W*NUM_CH-1:0]  ch_error,
  output logic                     busy,
  output logic                     done,
  output logic [CH_IDX_W-1:0]      cur_ch,
  output logic [7:0]               pass_cnt,
  output logic [TOT_W-1:0]         err_total,
  output logic [ERR_W-1:0]         last_err,
  output logic [NUM_CH-1:0]        fail_mask,
  output logic [NUM_CH-1:0]        tmo_mask
);

  localparam int PTR_W = CH_IDX_W + 1;
  localparam int SUM_W = ((TOT_W > ERR_W) ? TOT_W : ERR_W) + 1;

  state_t                state_reg, state_next;
  logic [7:0]            passes_reg;
  logic [NUM_CH-1:0]     enable_reg;
  logic [PTR_W-1:0]      ptr_reg;
  logic [CH_IDX_W-1:0]   cur_ch_reg;
  logic [31:0]           tmo_cnt_reg;
  logic [ERR_W-1:0]      sample_reg;
  logic                  abort_reg;
  logic                  done_reg;
  logic [7:0]            pass_cnt_reg;
  logic [TOT_W-1:0]      err_total_reg;
  logic [ERR_W-1:0]      last_err_reg;
  logic [NUM_CH-1:0]     fail_mask_reg;
  logic [NUM_CH-1:0]     tmo_mask_reg;

  logic [CH_IDX_W-1:0]   pick_idx;
  logic                  pick_valid;
  logic [NUM_CH-1:0]     sel_oh;
  logic                  fin_sel;
  logic                  tmo_hit;
  logic                  last_pass;
  logic [ERR_W-1:0]      err_sel;
  logic [SUM_W-1:0]      sum_full;
  logic [TOT_W-1:0]      total_next;

  rs422_ch_pick #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_pick (
    .mask  (enable_reg),
    .ptr   (ptr_reg),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sel
    assign sel_oh[gi] = (cur_ch_reg == CH_IDX_W'(gi));
  end

  always_comb begin
    err_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_oh[i]) err_sel = ch_error[ERR_W*i +: ERR_W];
    end
  end

  assign fin_sel   = |(ch_finish & sel_oh);
  assign tmo_hit   = (tmo_cnt_reg == TIMEOUT_CYC - 32'd1);
  assign last_pass = (passes_reg != 8'd0) &&
                     ({1'b0, pass_cnt_reg} + 9'd1 == {1'b0, passes_reg});

  // Accumulate in a wider sum so any carry out of TOT_W forces all-ones.
  assign sum_full   = SUM_W'(err_total_reg) + SUM_W'(sample_reg);
  assign total_next = (|sum_full[SUM_W-1:TOT_W]) ? {TOT_W{1'b1}} : sum_full[TOT_W-1:0];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:    if (run) state_next = (ch_enable == '0) ? ST_FINISH : ST_SELECT;
      ST_SELECT:  state_next = pick_valid ? ST_START : ST_NEXT;
      ST_START:   state_next = ST_WAIT;
      ST_WAIT:    if (fin_sel || tmo_hit) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = abort_reg ? ST_FINISH : ST_SELECT;
      ST_NEXT:    state_next = (last_pass || abort_reg) ? ST_FINISH : ST_SELECT;
      ST_FINISH:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ch_start = (state_reg == ST_START) ? sel_oh : '0;
    busy     = (state_reg != ST_IDLE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      passes_reg    <= '0;
      enable_reg    <= '0;
      ptr_reg       <= '0;
      cur_ch_reg    <= '0;
      tmo_cnt_reg   <= '0;
      sample_reg    <= '0;
      abort_reg     <= 1'b0;
      done_reg      <= 1'b0;
      pass_cnt_reg  <= '0;
      err_total_reg <= '0;
      last_err_reg  <= '0;
      fail_mask_reg <= '0;
      tmo_mask_reg  <= '0;
    end else begin
      // done is registered out of FINISH so it coincides with busy falling.
      done_reg <= (state_reg == ST_FINISH);
      if (state_reg == ST_IDLE) abort_reg <= 1'b0;
      else if (abort)           abort_reg <= 1'b1;

      unique case (state_reg)
        ST_IDLE: begin
          if (run) begin
            passes_reg    <= passes;
            enable_reg    <= ch_enable;
            ptr_reg       <= '0;
            pass_cnt_reg  <= '0;
            err_total_reg <= '0;
            last_err_reg  <= '0;
            fail_mask_reg <= '0;
            tmo_mask_reg  <= '0;
          end
        end
        ST_SELECT: if (pick_valid) cur_ch_reg <= pick_idx;
        ST_START:  tmo_cnt_reg <= '0;
        ST_WAIT: begin
          tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
          if (fin_sel) begin
            sample_reg <= err_sel;
          end else if (tmo_hit) begin
            sample_reg   <= '0;
            tmo_mask_reg <= tmo_mask_reg | sel_oh;
          end
        end
        ST_CAPTURE: begin
          last_err_reg  <= sample_reg;
          err_total_reg <= total_next;
          if (sample_reg != '0) fail_mask_reg <= fail_mask_reg | sel_oh;
          ptr_reg <= PTR_W'(cur_ch_reg) + PTR_W'(1);
        end
        ST_NEXT: begin
          if (pass_cnt_reg != 8'hFF) pass_cnt_reg <= pass_cnt_reg + 8'd1;
          ptr_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign done      = done_reg;
  assign cur_ch    = cur_ch_reg;
  assign pass_cnt  = pass_cnt_reg;
  assign err_total = err_total_reg;
  assign last_err  = last_err_reg;
  assign fail_mask = fail_mask_reg;
  assign tmo_mask  = tmo_mask_reg;

endmodule

// File: tb/tb_rs422_test_sched.sv
// Directed bench for rs422_test_sched with simple behavioural channel testers.
module tb_rs422_test_sched;
  import rs422_pkg::*;

  localparam int NCH = 4;
  localparam int TW  = 8;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst = 1'b1;
  logic                 run = 1'b0;
  logic                 abort = 1'b0;
  logic [7:0]           passes = '0;
  logic [NCH-1:0]       ch_enable = '0;
  logic [NCH-1:0]       ch_start, ch_finish, fail_mask, tmo_mask;
  logic [32*NCH-1:0]    ch_error;
  logic                 busy, done;
  logic [3:0]           cur_ch;
  logic [7:0]           pass_cnt;
  logic [TW-1:0]        err_total;
  logic [31:0]          last_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] err_val [NCH];
  int          lat     [NCH];
  logic        hang    [NCH];
  int          cnt     [NCH];
  int          starts  [NCH];
  int          start_cyc [NCH];
  int          snap    [NCH];
  int          cyc = 0;
  int          dones = 0;
  int          bad_oh = 0;
  int          d0;

  always #5 sys_clk = ~sys_clk;

  rs422_test_sched #(
    .NUM_CH      (NCH),
    .TIMEOUT_CYC (32'd100),
    .TOT_W       (TW)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .run       (run),
    .abort     (abort),
    .passes    (passes),
    .ch_enable (ch_enable),
    .ch_start  (ch_start),
    .ch_finish (ch_finish),
    .ch_error  (ch_error),
    .busy      (busy),
    .done      (done),
    .cur_ch    (cur_ch),
    .pass_cnt  (pass_cnt),
    .err_total (err_total),
    .last_err  (last_err),
    .fail_mask (fail_mask),
    .tmo_mask  (tmo_mask)
  );

  // Tester model: FINISH lat cycles after START; ERROR is junk unless FINISH.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_tst
    assign ch_finish[gi]          = (cnt[gi] == 1);
    assign ch_error[32*gi +: 32]  = ch_finish[gi] ? err_val[gi] : 32'hDEAD_BEEF;
  end

  initial begin
    for (int i = 0; i < NCH; i++) begin
      cnt[i] = 0; starts[i] = 0; start_cyc[i] = 0;
    end
  end

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (done) dones <= dones + 1;
    if (ch_start != '0 && !$onehot(ch_start)) bad_oh <= bad_oh + 1;
    for (int i = 0; i < NCH; i++) begin
      if (ch_start[i]) begin
        starts[i]    <= starts[i] + 1;
        start_cyc[i] <= cyc;
        cnt[i]       <= hang[i] ? 0 : lat[i];
      end else if (cnt[i] != 0) begin
        cnt[i] <= cnt[i] - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic take_snap();
    for (int i = 0; i < NCH; i++) snap[i] = starts[i];
    d0 = dones;
  endtask

  task automatic set_err(input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    err_val[0] = e0; err_val[1] = e1; err_val[2] = e2; err_val[3] = e3;
  endtask

  task automatic do_run(input logic [7:0] p, input logic [NCH-1:0] en);
    @(negedge sys_clk);
    passes = p; ch_enable = en; run = 1'b1;
    @(negedge sys_clk);
    run = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string tag);
    int k = 0;
    while (done !== 1'b1 && k < lim) begin
      @(negedge sys_clk);
      k++;
    end
    chk(tag, 128'(done), 128'd1);
  endtask

  task automatic wait_start(input int ch, input int base, input string tag);
    int k = 0;
    while (starts[ch] == base && k < 300) begin
      @(negedge sys_clk);
      k++;
    end
    chk(tag, 128'(starts[ch] - base), 128'd1);
  endtask

  function automatic logic [127:0] all_out();
    return 128'({ch_start, busy, done, cur_ch, pass_cnt, err_total, last_err, fail_mask, tmo_mask});
  endfunction

  initial begin
    for (int i = 0; i < NCH; i++) begin
      lat[i] = i + 1; hang[i] = 1'b0; err_val[i] = '0;
    end
    repeat (3) @(negedge sys_clk);
    chk("reset_outputs", all_out(), 128'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // One pass over all four channels, errors 0,3,0,7.
    set_err(32'd0, 32'd3, 32'd0, 32'd7);
    take_snap();
    do_run(8'd1, 4'b1111);
    chk("t1_busy", 128'(busy), 128'd1);
    wait_done(200, "t1_done");
    chk("t1_total", 128'(err_total), 128'd10);
    chk("t1_fail", 128'(fail_mask), 128'b1010);
    chk("t1_pass", 128'(pass_cnt), 128'd1);
    chk("t1_last", 128'(last_err), 128'd7);
    chk("t1_busy_end", 128'(busy), 128'd0);
    chk("t1_starts", 128'({starts[0]-snap[0], starts[1]-snap[1], starts[2]-snap[2], starts[3]-snap[3]}),
        128'({32'd1, 32'd1, 32'd1, 32'd1}));
    chk("t1_order", 128'(start_cyc[0] < start_cyc[1] && start_cyc[1] < start_cyc[2] &&
                         start_cyc[2] < start_cyc[3]), 128'd1);
    @(negedge sys_clk);
    chk("t1_done_pulse", 128'(done), 128'd0);
    chk("t1_done_count", 128'(dones - d0), 128'd1);

    // Three passes over ch0 and ch2, two errors each.
    set_err(32'd2, 32'd2, 32'd2, 32'd2);
    take_snap();
    do_run(8'd3, 4'b0101);
    wait_done(300, "t2_done");
    chk("t2_starts", 128'({starts[0]-snap[0], starts[1]-snap[1], starts[2]-snap[2], starts[3]-snap[3]}),
        128'({32'd3, 32'd0, 32'd3, 32'd0}));
    chk("t2_total", 128'(err_total), 128'd12);
    chk("t2_pass", 128'(pass_cnt), 128'd3);
    chk("t2_fail", 128'(fail_mask), 128'b0101);

    // ch1 never finishes: timeout, then ch2 and ch3 still run.
    set_err(32'd1, 32'd9, 32'd4, 32'd0);
    hang[1] = 1'b1;
    take_snap();
    do_run(8'd1, 4'b1111);
    wait_done(400, "t3_done");
    hang[1] = 1'b0;
    chk("t3_tmo", 128'(tmo_mask), 128'b0010);
    chk("t3_gap", 128'(start_cyc[2] - start_cyc[1]), 128'd103);
    chk("t3_total", 128'(err_total), 128'd5);
    chk("t3_fail", 128'(fail_mask), 128'b0101);
    chk("t3_ch3_run", 128'(starts[3] - snap[3]), 128'd1);
    chk("t3_last", 128'(last_err), 128'd0);

    // Continuous mode, abort while ch2 is waiting.
    set_err(32'd1, 32'd1, 32'd1, 32'd1);
    lat[2] = 20;
    take_snap();
    do_run(8'd0, 4'b1111);
    wait_start(2, snap[2], "t4_ch2_start");
    @(negedge sys_clk);
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    wait_done(200, "t4_done");
    chk("t4_no_ch3", 128'(starts[3] - snap[3]), 128'd0);
    chk("t4_pass", 128'(pass_cnt), 128'd0);
    chk("t4_total", 128'(err_total), 128'd3);
    chk("t4_fail", 128'(fail_mask), 128'b0111);
    lat[2] = 3;

    // Saturation of the 8-bit total.
    set_err(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
    do_run(8'd1, 4'b0001);
    wait_done(100, "t5a_done");
    chk("t5a_total", 128'(err_total), 128'hFF);
    chk("t5a_last", 128'(last_err), 128'hFFFF_FFFF);
    set_err(32'hF0, 32'h20, 32'd0, 32'd0);
    do_run(8'd1, 4'b0011);
    wait_done(100, "t5b_done");
    chk("t5b_total", 128'(err_total), 128'hFF);
    set_err(32'h7F, 32'h80, 32'd0, 32'd0);
    do_run(8'd1, 4'b0011);
    wait_done(100, "t5c_done");
    chk("t5c_total", 128'(err_total), 128'hFF);
    set_err(32'h7F, 32'h7F, 32'd0, 32'd0);
    do_run(8'd1, 4'b0011);
    wait_done(100, "t5d_done");
    chk("t5d_total", 128'(err_total), 128'hFE);

    // Empty mask: done two cycles after run, no starts.
    take_snap();
    @(negedge sys_clk);
    ch_enable = '0; passes = 8'd1; run = 1'b1;
    @(negedge sys_clk);
    run = 1'b0;
    chk("t6_mid", 128'({busy, done}), 128'b10);
    @(negedge sys_clk);
    chk("t6_done", 128'({busy, done}), 128'b01);
    chk("t6_no_start", 128'((starts[0]-snap[0]) + (starts[1]-snap[1]) +
                            (starts[2]-snap[2]) + (starts[3]-snap[3])), 128'd0);
    chk("t6_pass", 128'(pass_cnt), 128'd0);

    // Reset while ch0 is in WAIT, then a normal run.
    lat[0] = 10;
    set_err(32'd5, 32'd0, 32'd0, 32'd0);
    take_snap();
    do_run(8'd1, 4'b0011);
    wait_start(0, snap[0], "t7_ch0_start");
    chk("t7_busy_pre", 128'(busy), 128'd1);
    sys_rst = 1'b1;
    #1;
    chk("t7_rst_outputs", all_out(), 128'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (15) @(negedge sys_clk);
    chk("t7_idle_after", all_out(), 128'd0);
    lat[0] = 1;
    set_err(32'd0, 32'd0, 32'd0, 32'd0);
    do_run(8'd1, 4'b0011);
    wait_done(100, "t7_done");
    chk("t7_result", 128'({pass_cnt, err_total, tmo_mask, fail_mask}), 128'({8'd1, 8'd0, 4'd0, 4'd0}));

    chk("start_onehot", 128'(bad_oh), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs422_test_sched.md
Name: rs422_test_sched

Overview:
- Sequences a bank of NUM_CH RS422 loopback channel testers; each channel tester has a START input, a FINISH output and a 32-bit ERROR count output.
- Walks the enabled channels in ascending index order. For each channel it pulses START, waits for FINISH or a timeout, captures the error count and accumulates it.
- Repeats the sweep for a programmable number of passes, or continuously.
- Sits between the host/status register block and the per-channel testers; only one channel runs at a time, so the channels share the test time slot.

Parameters:
- NUM_CH, 4, number of channel testers (2..16).
- TIMEOUT_CYC, 32'd600000, max cycles to wait for FINISH after START before declaring a timeout.
- TOT_W, 48, width of the accumulated error total.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous reset, active-high.
- run  in  1  pulse; starts a test sequence. Ignored while busy.
- abort  in  1  pulse; ends the sequence after the current channel is resolved.
- passes  in  8  pass count sampled on run; 0 = continuous until abort.
- ch_enable  in  NUM_CH  channel enable mask, sampled on run.
- ch_start  out  NUM_CH  one-hot one-cycle START pulse to the selected channel.
- ch_finish  in  NUM_CH  FINISH from each channel.
- ch_error  in  32*NUM_CH  packed error counts; channel i occupies bits [32i+31:32i].
- busy  out  1  high from the cycle after run is accepted until done.
- done  out  1  one-cycle pulse at sequence end.
- cur_ch  out  4  index of the channel being tested.
- pass_cnt  out  8  completed passes.
- err_total  out  TOT_W  sum of captured errors, saturating.
- last_err  out  32  most recent captured count.
- fail_mask  out  NUM_CH  sticky; a channel had a nonzero error count.
- tmo_mask  out  NUM_CH  sticky; a channel timed out.

Behaviour:
- Reset (async, sys_rst=1): state IDLE. All outputs are 0, including ch_start, busy, done, cur_ch, pass_cnt, err_total, last_err, fail_mask and tmo_mask.
- States: IDLE, SELECT, START, WAIT, CAPTURE, NEXT, FINISH.
- IDLE: on run=1, latch passes and ch_enable, and clear pass_cnt, err_total, last_err, fail_mask and tmo_mask; go to SELECT.
  - If the latched mask is 0, go straight to FINISH: done pulse, no ch_start.
- SELECT: cur_ch = lowest enabled index >= the scan pointer (pointer resets to 0 each pass).
  - If none remains, go to NEXT; else go to START.
- START: drive ch_start[cur_ch]=1 for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT: increment the timeout counter each cycle.
  - On ch_finish[cur_ch]=1, sample ch_error slice cur_ch in that same cycle, then go to CAPTURE. ERROR is only guaranteed valid while FINISH is high.
  - Else, when the counter reaches TIMEOUT_CYC-1, set tmo_mask[cur_ch], take last_err=0, go to CAPTURE.
  - If FINISH and the timeout coincide, FINISH wins.
  - ch_finish of non-selected channels is ignored.
- CAPTURE:
  - last_err = sample.
  - err_total += sample, saturating at all-ones.
  - fail_mask[cur_ch] is set if sample != 0.
  - Pointer = cur_ch+1.
  - If abort was seen since START, go to FINISH; else go to SELECT.
- NEXT: pass_cnt += 1 (saturating at 255).
  - If passes != 0 and pass_cnt+1 == passes, go to FINISH.
  - Else, if abort is pending, go to FINISH.
  - Else reset the pointer and go to SELECT.
- FINISH: done=1 for one cycle, busy=0, go to IDLE. Status outputs hold until the next accepted run.
- busy = (state != IDLE). run while busy is ignored.
- abort in IDLE is ignored. abort is latched as a sticky flag while busy and cleared in IDLE.
- Minimum wait between a channel's START and its next START: 3 cycles (CAPTURE, SELECT, START). This guarantees the tester has returned to idle.
- Reset mid-sequence: immediate return to IDLE with all outputs 0. An in-flight channel is left to finish on its own; its FINISH is ignored.

Decomposition:
- Package rs422_pkg holds the state encoding (one-hot, 7 bits), the ERR_W=32 constant and the CH_IDX_W=4 constant.
- One sub-module, rs422_ch_pick: a combinational priority finder returning the lowest set bit of mask & ~((1<<ptr)-1) plus a valid flag.

Test Plan:
- NUM_CH=4, enable=4'b1111, passes=1; the tester models return errors 0,3,0,7 → ch_start pulses on ch0..3 in order, err_total=10, fail_mask=4'b1010, pass_cnt=1, one done pulse.
- enable=4'b0101, passes=3, each channel reports 2 errors → exactly 6 ch_start pulses (ch0,ch2 ×3), err_total=12, pass_cnt=3.
- ch1 never asserts FINISH, TIMEOUT_CYC=100 → ch1 abandoned 100 cycles after its start, tmo_mask=4'b0010, the sequence continues to ch2 and completes.
- passes=0, assert abort while ch2 is in WAIT → ch2 is captured, then done; no ch_start for ch3; pass_cnt=0.
- err_total preloaded near max (TOT_W=8 override) with sample 0xFFFFFFFF → err_total saturates at 8'hFF.
- enable=0 → done 2 cycles after run, no ch_start. Also: assert sys_rst in WAIT → all outputs 0 the same cycle, and a later run works normally.
